// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_pkg
//  Description : Shared definitions for the peripheral-bus master bridge:
//                FSM state encoding, bus field widths and the default
//                timeout / error-read-data constants.
//  Revision    : 1.0  initial release
// ============================================================================
package bus_pkg;

    localparam int BUS_AW = 32;
    localparam int BUS_DW = 32;
    localparam int BUS_SW = 4;

    // Defaults used by the bridge parameters.
    localparam int unsigned      TIMEOUT_CYCLES_DEFAULT = 255;
    localparam logic [BUS_DW-1:0] ERR_RDATA_DEFAULT     = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/bus_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : bus_master_bridge
//  Description : Single-outstanding initiator on the peripheral bus. Takes one
//                command from a valid/ready source, drives one bus access,
//                waits for ack or a bounded timeout and returns read data plus
//                an error flag on a valid/ready response channel.
//  Ports       : clk_i, rst_i              clock, synchronous active-high reset
//                cmd_*                     command channel (valid/ready)
//                rsp_*                     response channel (valid/ready)
//                bus_*                     peripheral bus (ce/we/sel/addr/data/ack)
//                err_cnt_o                 saturating count of timeouts
//  Revision    : 1.0  initial release
// ============================================================================
module bus_master_bridge
    import bus_pkg::*;
#(
    parameter int unsigned       TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT, // 1..255
    parameter logic [BUS_DW-1:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [BUS_AW-1:0] cmd_addr_i,
    input  logic [BUS_DW-1:0] cmd_wdata_i,
    input  logic [BUS_SW-1:0] cmd_sel_i,

    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [BUS_DW-1:0] rsp_rdata_o,
    output logic              rsp_err_o,

    output logic              bus_ce_o,
    output logic              bus_we_o,
    output logic [BUS_SW-1:0] bus_sel_o,
    output logic [BUS_AW-1:0] bus_addr_o,
    output logic [BUS_DW-1:0] bus_data_o,
    input  logic              bus_ack_i,
    input  logic [BUS_DW-1:0] bus_data_i,

    output logic [7:0]        err_cnt_o
);

    // Value of the timeout counter in the last cycle an ack is still honoured.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e     r_state;
    logic [7:0] r_tmo_cnt;

    // Ready is a pure decode of the state, so a command can never be taken in
    // the same edge that completes the response handshake.
    assign cmd_ready_o = (r_state == IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_tmo_cnt   <= 8'd0;
            bus_ce_o    <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= '0;
            bus_addr_o  <= '0;
            bus_data_o  <= '0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            err_cnt_o   <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        bus_we_o   <= cmd_we_i;
                        bus_addr_o <= cmd_addr_i;
                        bus_data_o <= cmd_wdata_i;
                        bus_sel_o  <= cmd_sel_i;
                        bus_ce_o   <= 1'b1;
                        r_tmo_cnt  <= 8'd0;
                        r_state    <= ACCESS;
                    end
                end

                ACCESS: begin
                    r_tmo_cnt <= r_tmo_cnt + 8'd1;
                    // Ack is checked first so an ack in the final timeout
                    // cycle still completes without error.
                    if (bus_ack_i) begin
                        bus_ce_o    <= 1'b0;
                        rsp_rdata_o <= bus_we_o ? '0 : bus_data_i;
                        rsp_err_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        r_state     <= RESP;
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        bus_ce_o    <= 1'b0;
                        rsp_rdata_o <= bus_we_o ? '0 : ERR_RDATA;
                        rsp_err_o   <= 1'b1;
                        rsp_valid_o <= 1'b1;
                        if (err_cnt_o != 8'hFF) begin
                            err_cnt_o <= err_cnt_o + 8'd1;
                        end
                        r_state     <= RESP;
                    end
                end

                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        r_state     <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_master_bridge
//  Description : Directed self-checking bench for bus_master_bridge with a
//                small gpio-style slave (0x00 = input pins, 0x04 = output
//                register). Writes ack combinationally, reads ack after a
//                programmable number of ce cycles; other addresses never ack.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bus_master_bridge;

    localparam logic [31:0] TB_ERR_RDATA = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        bus_ce, bus_we, bus_ack;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [7:0]  err_cnt;

    // Slave model state
    logic [7:0]  slv_cnt;
    logic [7:0]  rd_lat;
    logic [31:0] pins;
    logic [31:0] pin_o;
    logic        mapped;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bus_master_bridge #(
        .TIMEOUT_CYCLES (4),
        .ERR_RDATA      (TB_ERR_RDATA)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_addr_i  (cmd_addr),
        .cmd_wdata_i (cmd_wdata),
        .cmd_sel_i   (cmd_sel),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .bus_ce_o    (bus_ce),
        .bus_we_o    (bus_we),
        .bus_sel_o   (bus_sel),
        .bus_addr_o  (bus_addr),
        .bus_data_o  (bus_wdata),
        .bus_ack_i   (bus_ack),
        .bus_data_i  (bus_rdata),
        .err_cnt_o   (err_cnt)
    );

    // gpio-style slave
    assign mapped    = (bus_addr == 32'h0) || (bus_addr == 32'h4);
    assign bus_ack   = bus_ce && mapped && (bus_we || (slv_cnt == rd_lat));
    assign bus_rdata = (bus_ack && !bus_we) ? ((bus_addr == 32'h0) ? pins : pin_o)
                                             : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (rst) begin
            slv_cnt <= 8'd0;
            pin_o   <= 32'h0;
        end else begin
            slv_cnt <= (bus_ce && !bus_ack) ? slv_cnt + 8'd1 : 8'd0;
            if (bus_ce && bus_we && bus_ack && bus_addr == 32'h4) begin
                for (int i = 0; i < 4; i++) begin
                    if (bus_sel[i]) pin_o[8*i +: 8] <= bus_wdata[8*i +: 8];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command and step through the accept edge; returns in cycle 1.
    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] sel);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_sel   = sel;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || bus_ce !== 1'b0 ||
            err_cnt !== 8'd0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 ||
            bus_we !== 1'b0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0 || bus_sel !== 4'h0) begin
            bad++;
            $display("FAIL reset_state: ready=%b rsp_valid=%b ce=%b err_cnt=%0d rdata=%h err=%b we=%b addr=%h data=%h sel=%h, required ready=1 and all others 0",
                     cmd_ready, rsp_valid, bus_ce, err_cnt, rsp_rdata, rsp_err, bus_we, bus_addr, bus_wdata, bus_sel);
        end
    endtask

    task automatic test_write();
        int lat = 1;
        int ce_cyc = 0;
        rsp_ready = 1'b1;
        issue(1'b1, 32'h4, 32'h0000_00A5, 4'hF);
        total++;
        if (bus_ce !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 32'h4 || bus_wdata !== 32'hA5 || bus_sel !== 4'hF) begin
            bad++;
            $display("FAIL write_bus_fields: ce=%b we=%b addr=%h data=%h sel=%h, required 1 1 00000004 000000a5 f",
                     bus_ce, bus_we, bus_addr, bus_wdata, bus_sel);
        end
        while (!rsp_valid && lat < 20) begin
            if (bus_ce) ce_cyc++;
            tick();
            lat++;
        end
        total++;
        if (ce_cyc != 1 || lat != 2) begin
            bad++;
            $display("FAIL write_latency: ce_cycles=%0d rsp_cycle=%0d, required 1 and 2", ce_cyc, lat);
        end
        total++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 || bus_ce !== 1'b0) begin
            bad++;
            $display("FAIL write_response: valid=%b err=%b rdata=%h ce=%b, required 1 0 00000000 0",
                     rsp_valid, rsp_err, rsp_rdata, bus_ce);
        end
        total++;
        if (pin_o !== 32'h0000_00A5) begin
            bad++;
            $display("FAIL write_pin_o: pin_o=%h, required 000000a5", pin_o);
        end
        tick();
        total++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL write_handshake: rsp_valid=%b ready=%b, required 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_read();
        int lat = 1;
        int ce_cyc = 0;
        rsp_ready = 1'b1;
        rd_lat    = 8'd1;
        pins      = 32'h1234_5678;
        issue(1'b0, 32'h0, 32'h0, 4'hF);
        while (!rsp_valid && lat < 20) begin
            if (bus_ce) ce_cyc++;
            tick();
            lat++;
        end
        total++;
        if (ce_cyc != 2 || lat != 3) begin
            bad++;
            $display("FAIL read_latency: ce_cycles=%0d rsp_cycle=%0d, required 2 and 3", ce_cyc, lat);
        end
        total++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h1234_5678) begin
            bad++;
            $display("FAIL read_response: valid=%b err=%b rdata=%h, required 1 0 12345678",
                     rsp_valid, rsp_err, rsp_rdata);
        end
        tick();
    endtask

    task automatic test_timeout();
        int lat = 1;
        int ce_cyc = 0;
        rsp_ready = 1'b1;
        issue(1'b0, 32'h100, 32'h0, 4'hF);
        while (!rsp_valid && lat < 20) begin
            if (bus_ce) ce_cyc++;
            tick();
            lat++;
        end
        total++;
        if (ce_cyc != 4 || lat != 5 || bus_ce !== 1'b0) begin
            bad++;
            $display("FAIL timeout_latency: ce_cycles=%0d rsp_cycle=%0d ce=%b, required 4 5 0", ce_cyc, lat, bus_ce);
        end
        total++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== TB_ERR_RDATA || err_cnt !== 8'd1) begin
            bad++;
            $display("FAIL timeout_response: valid=%b err=%b rdata=%h err_cnt=%0d, required 1 1 deadbeef 1",
                     rsp_valid, rsp_err, rsp_rdata, err_cnt);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int lat = 1;
        logic hold_ok = 1'b1;
        rsp_ready = 1'b0;
        rd_lat    = 8'd1;
        pins      = 32'hCAFE_F00D;
        issue(1'b0, 32'h0, 32'h0, 4'hF);
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        total++;
        if (lat != 3 || rsp_rdata !== 32'hCAFE_F00D || rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL bp_first_response: rsp_cycle=%0d rdata=%h err=%b, required 3 cafef00d 0", lat, rsp_rdata, rsp_err);
        end
        // Second command waits while the response is stalled.
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_addr  = 32'h4;
        cmd_wdata = 32'h0000_003C;
        cmd_sel   = 4'hF;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE_F00D || rsp_err !== 1'b0 ||
                cmd_ready !== 1'b0 || bus_ce !== 1'b0) hold_ok = 1'b0;
            tick();
        end
        total++;
        if (!hold_ok) begin
            bad++;
            $display("FAIL bp_hold: response not held stable or command accepted, now valid=%b rdata=%h ready=%b ce=%b, required 1 cafef00d 0 0",
                     rsp_valid, rsp_rdata, cmd_ready, bus_ce);
        end
        rsp_ready = 1'b1;
        tick();
        total++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || bus_ce !== 1'b0) begin
            bad++;
            $display("FAIL bp_handshake_edge: valid=%b ready=%b ce=%b, required 0 1 0", rsp_valid, cmd_ready, bus_ce);
        end
        tick();
        cmd_valid = 1'b0;
        total++;
        if (bus_ce !== 1'b1 || bus_we !== 1'b1 || bus_wdata !== 32'h3C) begin
            bad++;
            $display("FAIL bp_second_accept: ce=%b we=%b data=%h, required 1 1 0000003c", bus_ce, bus_we, bus_wdata);
        end
        tick();
        tick();
        total++;
        if (pin_o !== 32'h0000_003C || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_second_done: pin_o=%h ready=%b, required 0000003c 1", pin_o, cmd_ready);
        end
    endtask

    task automatic test_ack_last();
        int lat = 1;
        int ce_cyc = 0;
        rsp_ready = 1'b1;
        rd_lat    = 8'd3;
        issue(1'b0, 32'h4, 32'h0, 4'hF);
        while (!rsp_valid && lat < 20) begin
            if (bus_ce) ce_cyc++;
            tick();
            lat++;
        end
        total++;
        if (ce_cyc != 4 || lat != 5) begin
            bad++;
            $display("FAIL ack_last_latency: ce_cycles=%0d rsp_cycle=%0d, required 4 and 5", ce_cyc, lat);
        end
        total++;
        if (rsp_err !== 1'b0 || rsp_rdata !== 32'h0000_003C || err_cnt !== 8'd1) begin
            bad++;
            $display("FAIL ack_last_response: err=%b rdata=%h err_cnt=%0d, required 0 0000003c 1",
                     rsp_err, rsp_rdata, err_cnt);
        end
        tick();
    endtask

    task automatic test_reset_mid_access();
        logic quiet = 1'b1;
        rsp_ready = 1'b1;
        issue(1'b0, 32'h200, 32'h0, 4'hF);
        tick();
        total++;
        if (bus_ce !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_pre: ce=%b, required 1", bus_ce);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (bus_ce !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || err_cnt !== 8'd0) begin
            bad++;
            $display("FAIL rst_mid_state: ce=%b valid=%b ready=%b err_cnt=%0d, required 0 0 1 0",
                     bus_ce, rsp_valid, cmd_ready, err_cnt);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rsp_valid !== 1'b0 || bus_ce !== 1'b0) quiet = 1'b0;
        end
        total++;
        if (!quiet) begin
            bad++;
            $display("FAIL rst_mid_no_response: a response or bus access appeared after reset, valid=%b ce=%b, required 0 0",
                     rsp_valid, bus_ce);
        end
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        cmd_sel   = 4'h0;
        rsp_ready = 1'b0;
        rd_lat    = 8'd1;
        pins      = 32'h0;
        #1;
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_backpressure();
        test_ack_last();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
